// File: rtl/ripple3_accum.sv
// Batch accumulator downstream of the 3-bit ripple-carry adder: sums COUNT
// {cout, s} samples into an ACC_W-bit total and offers it on a valid/ready port.
module ripple3_accum #(
   parameter int N     = 3,
   parameter int ACC_W = 8,
   parameter int COUNT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     s,
   input  logic             cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] total,
   output logic             overflow
);

   localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   logic [0:0]       state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;

   logic [ACC_W:0]   sample;
   logic [ACC_W:0]   sum;

   // One extra bit on the adder so the carry out of the accumulator is the overflow.
   assign sample = {{(ACC_W - N){1'b0}}, cout, s};
   assign sum    = {1'b0, acc} + sample;

   // Handshake outputs decode from state alone: no in_valid/out_ready feed-through.
   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign total     = acc;
   assign overflow  = ovf;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ACCUM;
         acc   <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  acc <= sum[ACC_W-1:0];
                  ovf <= ovf | sum[ACC_W];
                  if (cnt == CNT_LAST) begin
                     cnt   <= '0;
                     state <= HOLD;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               // Clearing here lets the next batch start accepting on the following cycle.
               if (out_ready) begin
                  state <= ACCUM;
                  acc   <= '0;
                  ovf   <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_ripple3_accum.sv
// Bench for ripple3_accum: directed scenarios plus randomized traffic against
// a queue-based batch model, on an 8-bit and a 5-bit accumulator in lockstep.
module tb_ripple3_accum;

   localparam int N     = 3;
   localparam int COUNT = 4;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [N-1:0] s = '0;
   logic       cout = 1'b0;
   logic       out_ready = 1'b1;

   logic       in_ready, out_valid, overflow;
   logic [7:0] total;
   logic       in_ready5, out_valid5, overflow5;
   logic [4:0] total5;

   int checks = 0;
   int errors = 0;

   always #5 if (clk_en) clk = ~clk;

   ripple3_accum #(.N(N), .ACC_W(8), .COUNT(COUNT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .s(s), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
      .total(total), .overflow(overflow));

   ripple3_accum #(.N(N), .ACC_W(5), .COUNT(COUNT)) dut5 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready5),
      .s(s), .cout(cout), .out_valid(out_valid5), .out_ready(out_ready),
      .total(total5), .overflow(overflow5));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit vld, input int v);
      in_valid = vld;
      {cout, s} = 4'(v);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #3;
      checks++;
      if (total !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_noclk: got total=%0d ovf=%b ov=%b ir=%b want 0 0 0 1",
                  total, overflow, out_valid, in_ready);
      end
      #2 reset = 1'b0;
      clk_en = 1'b1;
      repeat (3) tick();
      checks++;
      if (total !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle: got total=%0d ovf=%b ov=%b ir=%b want 0 0 0 1",
                  total, overflow, out_valid, in_ready);
      end
   endtask

   task automatic test_adder_vectors;
      int vals[4] = '{7, 5, 7, 9};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, vals[i]);
         tick();
      end
      drive(1'b0, 0);
      checks++;
      if (out_valid !== 1'b1 || total !== 8'd28 || overflow !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL adder_batch: got ov=%b total=%0d ovf=%b ir=%b want 1 28 0 0",
                  out_valid, total, overflow, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || total !== 8'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL adder_handshake: got ov=%b total=%0d ir=%b want 0 0 1",
                  out_valid, total, in_ready);
      end
   endtask

   task automatic test_gapped;
      bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      int seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(pat[i], 2);
         tick();
         if (pat[i]) seen++;
         checks++;
         if (out_valid !== (seen == COUNT) || total !== 8'(2 * seen)) begin
            errors++;
            $display("FAIL gapped_step%0d: got ov=%b total=%0d want %0d %0d",
                     i, out_valid, total, (seen == COUNT), 2 * seen);
         end
      end
      drive(1'b0, 0);
      tick();
   endtask

   task automatic test_back_pressure;
      out_ready = 1'b0;
      drive(1'b1, 15);
      repeat (4) tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || total !== 8'd60) begin
            errors++;
            $display("FAIL backpressure_hold%0d: got ov=%b ir=%b total=%0d want 1 0 60",
                     i, out_valid, in_ready, total);
         end
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || total !== 8'd0) begin
         errors++;
         $display("FAIL backpressure_release: got ov=%b ir=%b total=%0d want 0 1 0",
                  out_valid, in_ready, total);
      end
      tick();
      checks++;
      if (total !== 8'd15) begin
         errors++;
         $display("FAIL backpressure_resume: got total=%0d want 15", total);
      end
      repeat (3) tick();
      drive(1'b0, 0);
      checks++;
      if (out_valid !== 1'b1 || total !== 8'd60) begin
         errors++;
         $display("FAIL backpressure_batch2: got ov=%b total=%0d want 1 60", out_valid, total);
      end
      tick();
   endtask

   task automatic test_overflow;
      int exp5[4] = '{15, 30, 13, 28};
      bit expo[4] = '{0, 0, 1, 1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 15);
         tick();
         checks++;
         if (total5 !== 5'(exp5[i]) || overflow5 !== expo[i] || total !== 8'(15 * (i + 1)) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_step%0d: got t5=%0d o5=%b t8=%0d o8=%b want %0d %b %0d 0",
                     i, total5, overflow5, total, overflow, exp5[i], expo[i], 15 * (i + 1));
         end
      end
      drive(1'b0, 0);
      tick();
      checks++;
      if (overflow5 !== 1'b0 || total5 !== 5'd0 || out_valid5 !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: got o5=%b t5=%0d ov=%b want 0 0 0",
                  overflow5, total5, out_valid5);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b1;
      drive(1'b1, 9);
      tick();
      drive(1'b1, 6);
      tick();
      drive(1'b0, 0);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (total !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_async: got total=%0d ir=%b ov=%b ovf=%b want 0 1 0 0",
                  total, in_ready, out_valid, overflow);
      end
      #1 reset = 1'b0;
      drive(1'b1, 1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (out_valid !== (i == 3) || total !== 8'(i + 1)) begin
            errors++;
            $display("FAIL reset_mid_batch%0d: got ov=%b total=%0d want %0d %0d",
                     i, out_valid, total, (i == 3), i + 1);
         end
      end
      drive(1'b0, 0);
      tick();
   endtask

   task automatic test_random;
      int q[$];
      bit hold = 0;
      int r8, r5;
      bit o8, o5;
      for (int c = 0; c < 300; c++) begin
         int v = int'($urandom_range(0, 15));
         drive(1'($urandom_range(0, 1)), v);
         out_ready = ($urandom_range(0, 3) != 0);
         // Model the batch at the level of "which samples are in it".
         if (!hold && in_valid) begin
            q.push_back(v);
            if (q.size() == COUNT) hold = 1;
         end else if (hold && out_ready) begin
            hold = 0;
            q.delete();
         end
         tick();
         r8 = 0; r5 = 0; o8 = 0; o5 = 0;
         foreach (q[k]) begin
            r8 += q[k];
            if (r8 >= 256) begin r8 -= 256; o8 = 1; end
            r5 += q[k];
            if (r5 >= 32) begin r5 -= 32; o5 = 1; end
         end
         checks++;
         if (out_valid !== hold || in_ready !== !hold || total !== 8'(r8) || overflow !== o8 ||
             out_valid5 !== hold || total5 !== 5'(r5) || overflow5 !== o5) begin
            errors++;
            $display("FAIL random_c%0d: got ov=%b ir=%b t=%0d o=%b t5=%0d o5=%b want %b %b %0d %b %0d %b",
                     c, out_valid, in_ready, total, overflow, total5, overflow5,
                     hold, !hold, r8, o8, r5, o5);
         end
      end
      drive(1'b0, 0);
      out_ready = 1'b1;
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_adder_vectors();
      test_gapped();
      test_back_pressure();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
